// File: rtl/pong_game_ctrl.sv
// ============================================================================
// Module   : pong_game_ctrl
// Brief    : Pong match sequencer: scores, serve/point timing, rally gating,
//            end-of-game detection. Optional pause via macro PONG_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_game_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 30
) (
  input  logic       CLOCK_25,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] game_state
);

  localparam int MAX_DELAY = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int CW        = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [CW-1:0] POINT_LAST = CW'(POINT_DELAY - 1);
  localparam logic [3:0]    WIN4       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      p1_q, p1_d, p2_q, p2_d;
  logic [1:0]      win_q, win_d;
  logic            en_q, en_d, brst_q, brst_d, sl_q, sl_d;
  logic [3:0]      p1_inc, p2_inc;

  assign p1_inc = p1_q + 4'd1;
  assign p2_inc = p2_q + 4'd1;

`ifndef PONG_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    sl_d    = sl_q;
    brst_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SERVE;
          brst_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_RALLY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RALLY: begin
        // Misses take priority over pause; a simultaneous double miss replays the point
        if (miss_p1 && miss_p2) begin
          state_d = S_POINT;
          brst_d  = 1'b1;
          cnt_d   = '0;
        end else if (miss_p1) begin
          p2_d   = p2_inc;
          sl_d   = 1'b1;
          brst_d = 1'b1;
          cnt_d  = '0;
          if (p2_inc == WIN4) begin
            state_d = S_OVER;
            win_d   = 2'b10;
          end else begin
            state_d = S_POINT;
          end
        end else if (miss_p2) begin
          p1_d   = p1_inc;
          sl_d   = 1'b0;
          brst_d = 1'b1;
          cnt_d  = '0;
          if (p1_inc == WIN4) begin
            state_d = S_OVER;
            win_d   = 2'b01;
          end else begin
            state_d = S_POINT;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_btn) begin
          state_d = S_PAUSE;
        end
`endif
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d = S_SERVE;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 2'b00;
          sl_d    = 1'b0;
          brst_d  = 1'b1;
          cnt_d   = '0;
        end
      end
`ifdef PONG_PAUSE_EN
      S_PAUSE: begin
        if (pause_btn) state_d = S_RALLY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    en_d = (state_d == S_RALLY);
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= 2'b00;
      en_q    <= 1'b0;
      brst_q  <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      en_q    <= en_d;
      brst_q  <= brst_d;
      sl_q    <= sl_d;
    end
  end

  assign ball_enable = en_q;
  assign ball_reset  = brst_q;
  assign serve_left  = sl_q;
  assign score_p1    = p1_q;
  assign score_p2    = p2_q;
  assign winner      = win_q;
  assign game_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// Module   : tb_pong_game_ctrl
// Brief    : Directed self-checking bench for pong_game_ctrl (WIN=3, SERVE=3,
//            POINT=2); honours PONG_PAUSE_EN for the pause scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pong_game_ctrl;

  logic       CLOCK_25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, pause_btn = 1'b0;
  logic       miss_p1 = 1'b0, miss_p2 = 1'b0;
  logic       ball_enable, ball_reset, serve_left;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] game_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #20 CLOCK_25 = ~CLOCK_25;

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(3), .POINT_DELAY(2)) dut (
    .CLOCK_25   (CLOCK_25),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .pause_btn  (pause_btn),
    .miss_p1    (miss_p1),
    .miss_p2    (miss_p2),
    .ball_enable(ball_enable),
    .ball_reset (ball_reset),
    .serve_left (serve_left),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .winner     (winner),
    .game_state (game_state)
  );

  // Called at a falling edge; holds inputs across one rising edge.
  task automatic drive(input logic s, input logic m1, input logic m2,
                       input logic ft, input logic pb);
    start = s; miss_p1 = m1; miss_p2 = m2; frame_tick = ft; pause_btn = pb;
    @(negedge CLOCK_25);
    start = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0; frame_tick = 1'b0; pause_btn = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLOCK_25);
    n_cmp++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", game_state); end
    n_cmp++; if ({ball_enable, ball_reset, serve_left} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {ball_enable, ball_reset, serve_left}); end
    n_cmp++; if ({score_p1, score_p2, winner} !== 10'd0) begin n_fail++; $display("FAIL rst_scores got %h exp 0", {score_p1, score_p2, winner}); end
    rst_n = 1'b1;
    @(negedge CLOCK_25);
    n_cmp++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL idle_hold got %0d exp 0", game_state); end
  endtask

  task automatic test_serve;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL start_state got %0d exp 1", game_state); end
    n_cmp++; if (ball_reset !== 1'b1) begin n_fail++; $display("FAIL start_breset got %b exp 1", ball_reset); end
    n_cmp++; if (ball_enable !== 1'b0) begin n_fail++; $display("FAIL serve_en got %b exp 0", ball_enable); end
    @(negedge CLOCK_25);
    n_cmp++; if (ball_reset !== 1'b0) begin n_fail++; $display("FAIL breset_one_cycle got %b exp 0", ball_reset); end
    tick(2);
    n_cmp++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL serve_2ticks got %0d exp 1", game_state); end
    tick(1);
    n_cmp++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL rally_state got %0d exp 2", game_state); end
    n_cmp++; if (ball_enable !== 1'b1) begin n_fail++; $display("FAIL rally_en got %b exp 1", ball_enable); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (game_state !== 3'd2 || ball_reset !== 1'b0) begin n_fail++; $display("FAIL start_in_rally got st=%0d br=%b exp st=2 br=0", game_state, ball_reset); end
  endtask

  task automatic test_score;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (score_p1 !== 4'd1 || score_p2 !== 4'd0) begin n_fail++; $display("FAIL p1_score got %0d/%0d exp 1/0", score_p1, score_p2); end
    n_cmp++; if (serve_left !== 1'b0) begin n_fail++; $display("FAIL p1_serve got %b exp 0", serve_left); end
    n_cmp++; if (ball_reset !== 1'b1 || ball_enable !== 1'b0) begin n_fail++; $display("FAIL p1_br_en got br=%b en=%b exp br=1 en=0", ball_reset, ball_enable); end
    n_cmp++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL p1_point got %0d exp 3", game_state); end
    tick(1);
    n_cmp++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL point_1tick got %0d exp 3", game_state); end
    tick(1);
    n_cmp++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL point_to_serve got %0d exp 1", game_state); end
    tick(2);
    n_cmp++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL reserve_2ticks got %0d exp 1", game_state); end
    tick(1);
    n_cmp++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL reserve_rally got %0d exp 2", game_state); end
  endtask

  task automatic test_double_miss;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (score_p1 !== 4'd1 || score_p2 !== 4'd0) begin n_fail++; $display("FAIL dbl_scores got %0d/%0d exp 1/0", score_p1, score_p2); end
    n_cmp++; if (game_state !== 3'd3 || ball_reset !== 1'b1) begin n_fail++; $display("FAIL dbl_state got st=%0d br=%b exp st=3 br=1", game_state, ball_reset); end
    n_cmp++; if (serve_left !== 1'b0) begin n_fail++; $display("FAIL dbl_serve got %b exp 0", serve_left); end
    tick(5);
    n_cmp++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL dbl_back_rally got %0d exp 2", game_state); end
  endtask

  task automatic test_win;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (score_p2 !== 4'd1 || serve_left !== 1'b1 || game_state !== 3'd3) begin n_fail++; $display("FAIL win_m1 got p2=%0d sl=%b st=%0d exp 1/1/3", score_p2, serve_left, game_state); end
    tick(1);
    n_cmp++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL coincident_tick got %0d exp 3", game_state); end
    tick(4);
    n_cmp++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL win_rally1 got %0d exp 2", game_state); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (score_p2 !== 4'd2 || game_state !== 3'd3) begin n_fail++; $display("FAIL win_m2 got p2=%0d st=%0d exp 2/3", score_p2, game_state); end
    tick(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (score_p2 !== 4'd3 || winner !== 2'b10) begin n_fail++; $display("FAIL win_final got p2=%0d w=%b exp 3/10", score_p2, winner); end
    n_cmp++; if (game_state !== 3'd4 || ball_enable !== 1'b0 || ball_reset !== 1'b1) begin n_fail++; $display("FAIL over_state got st=%0d en=%b br=%b exp 4/0/1", game_state, ball_enable, ball_reset); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    n_cmp++; if (score_p1 !== 4'd1 || score_p2 !== 4'd3 || winner !== 2'b10 || game_state !== 3'd4) begin n_fail++; $display("FAIL over_frozen got p1=%0d p2=%0d w=%b st=%0d exp 1/3/10/4", score_p1, score_p2, winner, game_state); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || winner !== 2'b00) begin n_fail++; $display("FAIL restart_clear got p1=%0d p2=%0d w=%b exp 0/0/00", score_p1, score_p2, winner); end
    n_cmp++; if (game_state !== 3'd1 || ball_reset !== 1'b1 || serve_left !== 1'b0) begin n_fail++; $display("FAIL restart_state got st=%0d br=%b sl=%b exp 1/1/0", game_state, ball_reset, serve_left); end
  endtask

  task automatic test_async_reset;
    tick(2);
    #10;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (game_state !== 3'd0 || ball_enable !== 1'b0 || ball_reset !== 1'b0) begin n_fail++; $display("FAIL async_rst got st=%0d en=%b br=%b exp 0/0/0", game_state, ball_enable, ball_reset); end
    @(negedge CLOCK_25);
    rst_n = 1'b1;
    @(negedge CLOCK_25);
    n_cmp++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL post_rst_idle got %0d exp 0", game_state); end
  endtask

  task automatic test_pause;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    n_cmp++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL pause_setup got %0d exp 2", game_state); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PONG_PAUSE_EN
    n_cmp++; if (game_state !== 3'd5 || ball_enable !== 1'b0) begin n_fail++; $display("FAIL pause_enter got st=%0d en=%b exp 5/0", game_state, ball_enable); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (game_state !== 3'd5 || score_p2 !== 4'd0) begin n_fail++; $display("FAIL pause_ignore got st=%0d p2=%0d exp 5/0", game_state, score_p2); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    n_cmp++; if (game_state !== 3'd2 || ball_enable !== 1'b1) begin n_fail++; $display("FAIL pause_rally got st=%0d en=%b exp 2/1", game_state, ball_enable); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (game_state !== 3'd3 || score_p1 !== 4'd1) begin n_fail++; $display("FAIL miss_beats_pause got st=%0d p1=%0d exp 3/1", game_state, score_p1); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_score();
    test_double_miss();
    test_win();
    test_async_reset();
    test_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
